usb_transmitter: RTL and testbench

USB full-speed-style packet transmitter. It is the line-side stage that generates the differential stream consumed by usb_receiver.
- Serialises SYNC, PID and any queued data bytes taken from a first-word-fall-through TX FIFO.
- Applies NRZI encoding and bit stuffing, then terminates the packet with EOP.
- Used as the paired stimulus source for usb_receiver in loopback.

---
 rtl/usb_transmitter.sv | 164 ++++++++++++++++
 tb/tb_usb_transmitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transmitter.sv
// USB full-speed style packet transmitter: SYNC, PID and FIFO data bytes,
// NRZI encoded with bit stuffing and terminated by an SE0/J end-of-packet.
module usb_transmitter #(
    parameter int BIT_CLKS     = 8,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_r_enable,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [3:0]    r_pid;
    logic [7:0]    r_shift;
    logic [3:0]    r_bit_idx;
    logic [2:0]    r_ones;
    logic [1:0]    r_eop_cnt;
    logic          r_line;
    logic          r_fifo_re;
    logic          r_dp;
    logic          r_dm;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;
    logic          w_in_pkt;
    logic          w_stuff;
    logic          w_byte_done;
    logic [7:0]    w_next_byte;
    logic          w_bit;
    logic          w_to_eop;
    logic          w_line_nxt;

    // A new line symbol is launched whenever the bit-period counter wraps to zero.
    always_comb begin
        w_tick      = (r_clk_cnt == '0);
        w_in_pkt    = (r_state == S_SYNC) || (r_state == S_PID) || (r_state == S_DATA);
        w_stuff     = w_in_pkt && (r_ones == 3'd6);
        w_byte_done = r_bit_idx[3];
        w_next_byte = (r_state == S_SYNC) ? {~r_pid, r_pid} : fifo_r_data;
        w_bit       = w_byte_done ? w_next_byte[0] : r_shift[0];
        w_to_eop    = w_byte_done && (r_state != S_SYNC) && fifo_empty;
        w_line_nxt  = r_line ^ (w_stuff | ~w_bit);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_pid     <= 4'd0;
            r_shift   <= 8'd0;
            r_bit_idx <= 4'd0;
            r_ones    <= 3'd0;
            r_eop_cnt <= 2'd0;
            r_line    <= 1'b1;
            r_fifo_re <= 1'b0;
            r_dp      <= 1'b1;
            r_dm      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_fifo_re <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_state   <= S_SYNC;
                        r_pid     <= tx_pid;
                        r_shift   <= 8'h80;
                        r_bit_idx <= 4'd0;
                        r_ones    <= 3'd0;
                        r_clk_cnt <= '0;
                        r_line    <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_SYNC, S_PID, S_DATA: begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                    if (w_tick) begin
                        // An owed stuff bit always goes out before the next byte or EOP.
                        if (w_to_eop && !w_stuff) begin
                            r_state   <= S_EOP_SE0;
                            r_dp      <= 1'b0;
                            r_dm      <= 1'b0;
                            r_eop_cnt <= 2'd1;
                        end else begin
                            r_line <= w_line_nxt;
                            r_dp   <= w_line_nxt;
                            r_dm   <= ~w_line_nxt;
                            if (w_stuff) begin
                                r_ones <= 3'd0;
                            end else begin
                                r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
                                if (w_byte_done) begin
                                    r_shift   <= {1'b0, w_next_byte[7:1]};
                                    r_bit_idx <= 4'd1;
                                    if (r_state == S_SYNC) begin
                                        r_state <= S_PID;
                                    end else begin
                                        r_state   <= S_DATA;
                                        r_fifo_re <= 1'b1;
                                    end
                                end else begin
                                    r_shift   <= {1'b0, r_shift[7:1]};
                                    r_bit_idx <= r_bit_idx + 4'd1;
                                end
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                    if (w_tick) begin
                        if (r_eop_cnt == 2'(EOP_SE0_BITS)) begin
                            r_state <= S_EOP_J;
                            r_dp    <= 1'b1;
                            r_dm    <= 1'b0;
                            r_line  <= 1'b1;
                        end else begin
                            r_eop_cnt <= r_eop_cnt + 2'd1;
                        end
                    end
                end
                S_EOP_J: begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                    if (w_tick) begin
                        r_state   <= S_IDLE;
                        r_clk_cnt <= '0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_r_enable = r_fifo_re;
    assign d_plus        = r_dp;
    assign d_minus       = r_dm;
    assign tx_busy       = r_busy;
    assign tx_done       = r_done;

endmodule

// File: tb/tb_usb_transmitter.sv
// Directed bench for usb_transmitter: a line decoder undoes NRZI and stuffing
// and compares each recovered byte against a queue filled when stimulus is driven.
module tb_usb_transmitter;

    localparam int BIT_CLKS     = 8;
    localparam int EOP_SE0_BITS = 2;

    logic       clk      = 1'b0;
    logic       n_rst    = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid   = 4'd0;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_r_enable;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] mem [0:15];
    int         wr_ptr  = 0;
    int         rd_ptr  = 0;
    int         cyc     = 0;
    int         pop_cnt = 0;

    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    usb_transmitter #(
        .BIT_CLKS     (BIT_CLKS),
        .EOP_SE0_BITS (EOP_SE0_BITS)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .fifo_empty    (fifo_empty),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_r_data = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r_enable) begin
            pop_cnt <= pop_cnt + 1;
            if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
    endtask

    task automatic run_packet(input string name, input logic [3:0] pid, input int n,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input int exp_stuff, input bit poke_busy, input bit chain);
        logic [7:0] dat [3];
        logic [7:0] rx_byte;
        logic [7:0] sync_dp;
        logic       prev, b, jdp, jdm;
        bit         found, eop_j;
        int         pops0, t_first, t_done, ones, nbits, stuffs, stuff_bad;
        int         se0, dm_bad, samp, early_done, extra;
        dat = '{d0, d1, d2};
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[3:0]] = dat[i];
            wr_ptr++;
        end
        exp_q.push_back(8'h80);
        exp_q.push_back({~pid, pid});
        for (int i = 0; i < n; i++) exp_q.push_back(dat[i]);
        pops0 = pop_cnt;

        tx_pid   = pid;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check({name, "_busy_at_start"}, 32'(tx_busy), 32'd1);

        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (d_plus == 1'b0) found = 1;
            else @(negedge clk);
        end
        check({name, "_first_k_seen"}, 32'(found), 32'd1);
        t_first = cyc;

        prev = 1'b1; ones = 0; nbits = 0; rx_byte = 8'd0; stuffs = 0; stuff_bad = 0;
        se0 = 0; dm_bad = 0; samp = 0; eop_j = 0; early_done = 0; extra = 0;
        sync_dp = 8'd0; jdp = 1'b0; jdm = 1'b1;
        while (!eop_j && samp < 400) begin
            if (samp < 8) sync_dp[samp] = d_plus;
            if (!d_plus && !d_minus) begin
                se0++;
            end else if (se0 > 0) begin
                eop_j = 1;
                jdp   = d_plus;
                jdm   = d_minus;
            end else begin
                if (d_minus !== ~d_plus) dm_bad++;
                b    = (d_plus == prev);
                prev = d_plus;
                if (ones == 6) begin
                    if (b) stuff_bad++;
                    else stuffs++;
                    ones = 0;
                end else begin
                    ones    = b ? ones + 1 : 0;
                    rx_byte = {b, rx_byte[7:1]};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        if (exp_q.size() == 0) extra++;
                        else check({name, "_byte"}, 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
            if (!eop_j) begin
                for (int j = 0; j < BIT_CLKS; j++) begin
                    @(negedge clk);
                    tx_start = (poke_busy && samp == 20 && j == 0);
                    if (tx_done) early_done++;
                end
            end
            samp++;
        end
        check({name, "_eop_seen"}, 32'(eop_j), 32'd1);
        check({name, "_sync_line"}, 32'(sync_dp), 32'h2A);
        check({name, "_se0_bits"}, 32'(se0), 32'(EOP_SE0_BITS));
        check({name, "_eop_j"}, {30'd0, jdp, jdm}, 32'd2);
        check({name, "_dm_complement"}, 32'(dm_bad), 32'd0);
        check({name, "_stuff_bits"}, 32'(stuffs), 32'(exp_stuff));
        check({name, "_stuff_bad"}, 32'(stuff_bad), 32'd0);
        check({name, "_partial_bits"}, 32'(nbits), 32'd0);
        check({name, "_extra_bytes"}, 32'(extra), 32'd0);
        check({name, "_missing_bytes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_early_done"}, 32'(early_done), 32'd0);

        found = 0;
        for (int k = 0; k < 4 * BIT_CLKS && !found; k++) begin
            if (tx_done) found = 1;
            else @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(found), 32'd1);
        t_done = cyc;
        check({name, "_length"}, 32'(t_done - t_first),
              32'((16 + 8 * n + exp_stuff + EOP_SE0_BITS + 1) * BIT_CLKS));
        check({name, "_busy_at_done"}, 32'(tx_busy), 32'd0);
        check({name, "_pops"}, 32'(pop_cnt - pops0), 32'(n));
        exp_q.delete();
        if (!chain) begin
            @(negedge clk);
            check({name, "_done_one_cycle"}, 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        int busy_seen, line_bad, pops0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line", {30'd0, d_plus, d_minus}, 32'd2);
        check("reset_ctrl", {29'd0, tx_busy, tx_done, fifo_r_enable}, 32'd0);
        n_rst = 1'b1;

        busy_seen = 0; line_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_busy) busy_seen++;
            if (d_plus !== 1'b1 || d_minus !== 1'b0) line_bad++;
        end
        check("idle_busy", 32'(busy_seen), 32'd0);
        check("idle_line", 32'(line_bad), 32'd0);
        check("idle_pops", 32'(pop_cnt), 32'd0);

        run_packet("pid_only", 4'b0001, 0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        run_packet("three", 4'b0001, 3, 8'h00, 8'h40, 8'h61, 0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        run_packet("stuff", 4'b1011, 3, 8'hFF, 8'hF7, 8'hCF, 2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        run_packet("busy_ign", 4'b0110, 1, 8'hA5, 8'h00, 8'h00, 0, 1'b1, 1'b1);
        run_packet("b2b", 4'b0010, 2, 8'h3C, 8'h7E, 8'h00, 1, 1'b0, 1'b0);

        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_busy) busy_seen++;
        end
        check("after_b2b_idle", 32'(busy_seen), 32'd0);

        mem[wr_ptr[3:0]] = 8'h55; wr_ptr++;
        mem[wr_ptr[3:0]] = 8'hAA; wr_ptr++;
        pops0    = pop_cnt;
        tx_pid   = 4'b0011;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat ((16 + 4) * BIT_CLKS) @(negedge clk);
        check("mid_data_pop", 32'(pop_cnt - pops0), 32'd1);
        n_rst = 1'b0;
        #1;
        check("rst_mid_line", {30'd0, d_plus, d_minus}, 32'd2);
        check("rst_mid_ctrl", {29'd0, tx_busy, tx_done, fifo_r_enable}, 32'd0);
        @(negedge clk);
        n_rst  = 1'b1;
        wr_ptr = rd_ptr;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("post_rst_idle", {29'd0, d_plus, d_minus, tx_busy}, 32'd4);
        run_packet("after_rst", 4'b1100, 1, 8'h81, 8'h00, 8'h00, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
